// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
//   Bus between the UART receive path and its consumer (RX FIFO / APB
//   register block).
//
//   data_o        received data, right-aligned, unused upper bits 0
//   rx_done_o     one-clk pulse, frame complete
//   parity_err_o  parity mismatch for the frame in data_o
//   frame_err_o   a stop bit of the frame in data_o was sampled low
//   overrun_o     one-clk pulse, frame completed while the FIFO was full
//   fifo_full_i   RX FIFO full, driven by the consumer
//
//   master: the receiver. slave: the FIFO / register block.
// ---------------------------------------------------------------------------
interface uart_receiver_if;
  logic [7:0] data_o;
  logic       rx_done_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       fifo_full_i;

  modport master (
    output data_o, rx_done_o, parity_err_o, frame_err_o, overrun_o,
    input  fifo_full_i
  );

  modport slave (
    input  data_o, rx_done_o, parity_err_o, frame_err_o, overrun_o,
    output fifo_full_i
  );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   UART serial-to-parallel receiver. rx_i is synchronized, oversampled at
//   OVS x baud (tick_i), the start bit is qualified at its mid-point, then
//   5-8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits
//   are sampled at their mid-points. The completed frame is presented on the
//   rx_bus with error flags.
//
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   rx_en_i         receiver enable; dropping it mid-frame aborts the frame
//   rx_i            serial input, idle high, asynchronous to clk
//   tick_i          one-clk enable at OVS x baud
//   data_bit_num_i  00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i     parity bit present
//   parity_type_i   0=even, 1=odd
//   stop_bit_num_i  0=1 stop bit, 1=2 stop bits
//   rts_no          active-low request to send (registered)
//   rx_bus          data/status towards the RX FIFO, fifo_full_i back
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_en_i,
  input  logic                   rx_i,
  input  logic                   tick_i,
  input  logic [1:0]             data_bit_num_i,
  input  logic                   parity_en_i,
  input  logic                   parity_type_i,
  input  logic                   stop_bit_num_i,
  output logic                   rts_no,
  uart_receiver_if.master        rx_bus
);

  localparam int              CW        = $clog2(OVS);
  localparam logic [CW-1:0]   HALF_TICK = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]   LAST_TICK = CW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;

  logic [CW-1:0]          cnt_q, cnt_d;         // sample (tick) counter
  logic [2:0]             bit_cnt_q, bit_cnt_d; // data bits received
  logic                   stop_cnt_q, stop_cnt_d;
  logic [7:0]             shift_q, shift_d;

  // Frame configuration captured at the start bit.
  logic [1:0]             bits_q, bits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_type_q, par_type_d;
  logic                   stop2_q, stop2_d;

  // Per-frame error accumulators, published only when the frame completes.
  logic                   par_err_acc_q, par_err_acc_d;
  logic                   frm_err_acc_q, frm_err_acc_d;

  // Set when a frame ends with the line still low (break); a new start is
  // only accepted once the line has been seen high again.
  logic                   wait_high_q, wait_high_d;

  logic [7:0]             data_q, data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rts_q, rts_d;

  logic                   mid_bit;
  logic                   frm_now;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};
  assign mid_bit = tick_i && (cnt_q == LAST_TICK);
  // Frame error including the stop bit being sampled right now.
  assign frm_now = frm_err_acc_q | ~rx_s;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    bits_d        = bits_q;
    par_en_d      = par_en_q;
    par_type_d    = par_type_q;
    stop2_d       = stop2_q;
    par_err_acc_d = par_err_acc_q;
    frm_err_acc_d = frm_err_acc_q;
    wait_high_d   = wait_high_q;
    data_d        = data_q;
    rx_done_d     = 1'b0;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_d     = 1'b0;
    rts_d         = ~rx_en_i | fifo_full_w();

    if (!rx_en_i && (state_q inside {START, DATA, PARITY, STOP})) begin
      // Abort: drop the frame silently, published outputs keep their values.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d         = '0;
          bit_cnt_d     = '0;
          stop_cnt_d    = 1'b0;
          shift_d       = '0;
          par_err_acc_d = 1'b0;
          frm_err_acc_d = 1'b0;
          if (rx_s) wait_high_d = 1'b0;
          if (rx_en_i && tick_i && !rx_s && !wait_high_q) begin
            state_d    = START;
            bits_d     = data_bit_num_i;
            par_en_d   = parity_en_i;
            par_type_d = parity_type_i;
            stop2_d    = stop_bit_num_i;
          end
        end

        START: begin
          if (tick_i) begin
            if (cnt_q == HALF_TICK) begin
              cnt_d   = '0;
              // High at mid start bit is a glitch, not a start.
              state_d = rx_s ? IDLE : DATA;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        DATA: begin
          if (tick_i) cnt_d = cnt_q + CW'(1); // wraps at OVS-1 (power of 2)
          if (mid_bit) begin
            // Storing at the bit index leaves the word right-aligned and
            // zero-extended for 5-7 bit frames.
            shift_d[bit_cnt_q] = rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == {1'b1, bits_q}) begin // last index = N-1
              state_d = par_en_q ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (tick_i) cnt_d = cnt_q + CW'(1);
          if (mid_bit) begin
            par_err_acc_d = ((^shift_q) ^ par_type_q) != rx_s;
            state_d       = STOP;
          end
        end

        STOP: begin
          if (tick_i) cnt_d = cnt_q + CW'(1);
          if (mid_bit) begin
            frm_err_acc_d = frm_now;
            if (stop_cnt_q == stop2_q) begin
              // Publish on the sampling edge so rx_done_o is high one clk
              // after the last stop-bit sample.
              state_d      = DONE;
              data_d       = shift_q;
              parity_err_d = par_err_acc_q;
              frame_err_d  = frm_now;
              rx_done_d    = 1'b1;
              overrun_d    = fifo_full_w();
              wait_high_d  = ~rx_s;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end

        DONE: state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end
  end

  function automatic logic fifo_full_w();
    return rx_bus.fifo_full_i;
  endfunction

  // NOTE: all state updates use non-blocking assignments so every flop
  // samples its _d value from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sync_q        <= '1; // line idles high
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      // NOTE: the shift register is tiny and reset like every other flop;
      // this keeps data_o deterministic even before the first frame.
      shift_q       <= '0;
      bits_q        <= '0;
      par_en_q      <= 1'b0;
      par_type_q    <= 1'b0;
      stop2_q       <= 1'b0;
      par_err_acc_q <= 1'b0;
      frm_err_acc_q <= 1'b0;
      wait_high_q   <= 1'b0;
      data_q        <= '0;
      rx_done_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      rts_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      bits_q        <= bits_d;
      par_en_q      <= par_en_d;
      par_type_q    <= par_type_d;
      stop2_q       <= stop2_d;
      par_err_acc_q <= par_err_acc_d;
      frm_err_acc_q <= frm_err_acc_d;
      wait_high_q   <= wait_high_d;
      data_q        <= data_d;
      rx_done_q     <= rx_done_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      rts_q         <= rts_d;
    end
  end

  assign rx_bus.data_o       = data_q;
  assign rx_bus.rx_done_o    = rx_done_q;
  assign rx_bus.parity_err_o = parity_err_q;
  assign rx_bus.frame_err_o  = frame_err_q;
  assign rx_bus.overrun_o    = overrun_q;
  assign rts_no              = rts_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed and randomized frames for uart_receiver. The expected result of
//   every frame is computed from the frame's bits with plain arithmetic
//   (mask, reduction XOR over the data bits, stop bits sampled low).
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_en_i;
  logic       rx_i;
  logic       tick_i = 1'b0;
  logic [1:0] data_bit_num_i;
  logic       parity_en_i;
  logic       parity_type_i;
  logic       stop_bit_num_i;
  logic       rts_no;

  uart_receiver_if bus ();

  uart_receiver #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_en_i        (rx_en_i),
    .rx_i           (rx_i),
    .tick_i         (tick_i),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .rts_no         (rts_no),
    .rx_bus         (bus)
  );

  always #5 clk = ~clk;

  // One tick every 4 clks.
  logic [1:0] div = 2'd0;
  always @(posedge clk) begin
    div    <= div + 2'd1;
    tick_i <= (div == 2'd3);
  end

  // Pulse monitors, sampled away from the active edge.
  int done_cycles  = 0;
  int ovr_cycles   = 0;
  int ovr_alone    = 0;
  always @(negedge clk) begin
    if (bus.rx_done_o) done_cycles <= done_cycles + 1;
    if (bus.overrun_o) ovr_cycles <= ovr_cycles + 1;
    if (bus.overrun_o && !bus.rx_done_o) ovr_alone <= ovr_alone + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!tick_i) @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit pen,
                            input bit ptype, input bit pbit, input bit two_stop,
                            input bit s1, input bit s2, input bit release_line);
    data_bit_num_i = 2'(n - 5);
    parity_en_i    = pen;
    parity_type_i  = ptype;
    stop_bit_num_i = two_stop;
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(s1);
    if (two_stop) send_bit(s2);
    if (release_line) rx_i = 1'b1;
  endtask

  // Reference model.
  function automatic logic [7:0] m_data(input logic [7:0] d, input int n);
    return d & 8'((1 << n) - 1);
  endfunction
  function automatic logic m_good_parity(input logic [7:0] d, input int n, input bit ptype);
    return (^m_data(d, n)) ^ ptype;
  endfunction
  function automatic logic m_perr(input logic [7:0] d, input int n, input bit pen,
                                  input bit ptype, input bit pbit);
    return pen && (pbit != m_good_parity(d, n, ptype));
  endfunction

  task automatic check_frame(input string tag, input int done0, input logic [7:0] exp_d,
                             input logic exp_pe, input logic exp_fe);
    check({tag, "_done"}, done_cycles - done0, 1);
    check({tag, "_data"}, bus.data_o, exp_d);
    check({tag, "_perr"}, bus.parity_err_o, exp_pe);
    check({tag, "_ferr"}, bus.frame_err_o, exp_fe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    logic [7:0] last_data;
    logic [7:0] rd;
    int rn;
    bit rpen, rpt, rpbit, r2, rs1, rs2;

    reset_n = 1'b0; rx_en_i = 1'b0; rx_i = 1'b1; bus.fifo_full_i = 1'b0;
    data_bit_num_i = 2'b11; parity_en_i = 1'b0; parity_type_i = 1'b0; stop_bit_num_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data", bus.data_o, 8'h00);
    check("rst_done", bus.rx_done_o, 1'b0);
    check("rst_perr", bus.parity_err_o, 1'b0);
    check("rst_ferr", bus.frame_err_o, 1'b0);
    check("rst_ovr",  bus.overrun_o, 1'b0);
    check("rst_rts",  rts_no, 1'b1);
    reset_n = 1'b1;
    rx_en_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rts_enabled", rts_no, 1'b0);
    wait_ticks(2 * OVS);

    // 8N1 0xA5
    d0 = done_cycles;
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("8n1_a5", d0, m_data(8'hA5, 8), 1'b0, 1'b0);

    // 7E1 0x35: correct parity, then wrong parity
    d0 = done_cycles;
    send_frame(8'h35, 7, 1, 0, m_good_parity(8'h35, 7, 0), 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("7e1_ok", d0, m_data(8'h35, 7), 1'b0, 1'b0);
    d0 = done_cycles;
    send_frame(8'h35, 7, 1, 0, ~m_good_parity(8'h35, 7, 0), 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("7e1_bad", d0, m_data(8'h35, 7), 1'b1, 1'b0);

    // 5O2 0x1F, second stop low, line held low (break): exactly one frame
    d0 = done_cycles;
    send_frame(8'h1F, 5, 1, 1, m_good_parity(8'h1F, 5, 1), 1, 1, 0, 0);
    wait_ticks(12 * OVS);
    check_frame("5o2_brk", d0, m_data(8'h1F, 5), 1'b0, 1'b1);
    rx_i = 1'b1;
    wait_ticks(OVS);
    d0 = done_cycles;
    send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("rearm", d0, 8'h5A, 1'b0, 1'b0);
    last_data = 8'h5A;

    // Start glitch of 4 ticks
    d0 = done_cycles;
    rx_i = 1'b0;
    wait_ticks(4);
    rx_i = 1'b1;
    wait_ticks(2 * OVS);
    check("glitch_done", done_cycles - d0, 0);
    check("glitch_data", bus.data_o, last_data);
    check("glitch_ferr", bus.frame_err_o, 1'b0);

    // FIFO full: rts_no follows after one clk, overrun pulses with rx_done_o
    @(negedge clk);
    bus.fifo_full_i = 1'b1;
    check("rts_before", rts_no, 1'b0);
    @(posedge clk);
    #1;
    check("rts_after", rts_no, 1'b1);
    d0 = done_cycles; o0 = ovr_cycles;
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("ovr_3c", d0, 8'h3C, 1'b0, 1'b0);
    check("ovr_pulse", ovr_cycles - o0, 1);
    check("ovr_alone", ovr_alone, 0);
    bus.fifo_full_i = 1'b0;
    last_data = 8'h3C;

    // rx_en_i dropped mid-DATA aborts silently
    d0 = done_cycles;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rx_en_i = 1'b0;
    wait_ticks(OVS);
    rx_i = 1'b1;
    wait_ticks(10 * OVS);
    rx_en_i = 1'b1;
    wait_ticks(OVS);
    check("abort_done", done_cycles - d0, 0);
    check("abort_data", bus.data_o, last_data);

    // Reset mid-DATA, then a clean 8N1 0x81
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_data", bus.data_o, 8'h00);
    check("mrst_perr", bus.parity_err_o, 1'b0);
    check("mrst_ferr", bus.frame_err_o, 1'b0);
    check("mrst_rts",  rts_no, 1'b1);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(2 * OVS);
    d0 = done_cycles;
    send_frame(8'h81, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_ticks(OVS);
    check_frame("post_rst", d0, 8'h81, 1'b0, 1'b0);

    // Randomized frames against the reference model
    for (int k = 0; k < 12; k++) begin
      rd    = 8'($urandom);
      rn    = 5 + int'($urandom_range(3));
      rpen  = 1'($urandom);
      rpt   = 1'($urandom);
      r2    = 1'($urandom);
      rpbit = ($urandom_range(3) == 0) ? ~m_good_parity(rd, rn, rpt) : m_good_parity(rd, rn, rpt);
      rs1   = ($urandom_range(3) != 0);
      rs2   = ($urandom_range(3) != 0);
      d0 = done_cycles;
      send_frame(rd, rn, rpen, rpt, rpbit, r2, rs1, rs2, 1);
      wait_ticks(2 * OVS);
      check_frame($sformatf("rnd%0d", k), d0, m_data(rd, rn),
                  m_perr(rd, rn, rpen, rpt, rpbit), !rs1 || (r2 && !rs2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
